// File: rtl/fir_coef_bank_pkg.sv
// Shared constants and state encoding for the FIR coefficient bank and its neighbours.
package fir_coef_pkg;
  localparam int NTAPS          = 8;
  localparam int IDX_W          = 3;
  localparam int COEF_W_DEFAULT = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;
endpackage

// File: rtl/fir_coef_bank_if.sv
// Write port and coefficient stream of the FIR coefficient bank.
interface fir_coef_bank_if
  import fir_coef_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEFAULT
);
  logic              wr_en;
  logic [NTAPS-1:0]  wr_addr_oh;
  logic [COEF_W-1:0] wr_data;
  logic              wr_ready;
  logic              addr_err;
  logic [NTAPS-1:0]  loaded;
  logic              start;
  logic              busy;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic [IDX_W-1:0]  coef_idx;
  logic              coef_last;

  modport master (
    output wr_en, wr_addr_oh, wr_data, start, coef_ready,
    input  wr_ready, addr_err, loaded, busy, coef_valid, coef_data, coef_idx, coef_last
  );

  modport slave (
    input  wr_en, wr_addr_oh, wr_data, start, coef_ready,
    output wr_ready, addr_err, loaded, busy, coef_valid, coef_data, coef_idx, coef_last
  );
endinterface

// File: rtl/fir_coef_bank_oh_to_idx.sv
// One-hot tap address back to a binary index; inverse of the upstream tap-address encoder.
module oh_to_idx
  import fir_coef_pkg::*;
(
  input  logic [NTAPS-1:0] oh_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             is_onehot_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (oh_i[i]) idx_o = idx_o | IDX_W'(i);
    end
    is_onehot_o = $onehot(oh_i);
  end
endmodule

// File: rtl/fir_coef_bank.sv
// Eight-entry coefficient register bank, written by one-hot address and
// streamed in index order to the MAC stage over valid/ready.
module fir_coef_bank
  import fir_coef_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEFAULT
)(
  input  logic clk,
  input  logic rst_n,
  fir_coef_bank_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [COEF_W-1:0] coef_data_q;
  logic              valid_q, last_q, busy_q, addr_err_q;
  logic [NTAPS-1:0]  loaded_q;
  logic [COEF_W-1:0] bank_q [NTAPS];

  logic              wr_ready;
  logic              wr_take;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_onehot;
  logic [NTAPS-1:0]  entry_we;
  logic [IDX_W-1:0]  idx_d;
  logic [COEF_W-1:0] first_coef_d;

  oh_to_idx u_oh_to_idx (
    .oh_i        (bus.wr_addr_oh),
    .idx_o       (wr_idx),
    .is_onehot_o (wr_onehot)
  );

  assign wr_ready = (state_q == IDLE);
  assign wr_take  = bus.wr_en & wr_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_entry
      assign entry_we[gi] = wr_take & wr_onehot & (wr_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n)            bank_q[gi] <= '0;
        else if (entry_we[gi]) bank_q[gi] <= bus.wr_data;
      end
    end
  endgenerate

  assign idx_d = idx_q + 1'b1;
  // A write landing on entry 0 in the start cycle must be visible in the first beat.
  assign first_coef_d = entry_we[0] ? bus.wr_data : bank_q[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      coef_data_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      loaded_q    <= '0;
    end else begin
      addr_err_q <= 1'b0;
      loaded_q   <= loaded_q | entry_we;
      case (state_q)
        IDLE: begin
          if (wr_take && !wr_onehot) addr_err_q <= 1'b1;
          if (bus.start) begin
            state_q     <= STREAM;
            idx_q       <= '0;
            coef_data_q <= first_coef_d;
            valid_q     <= 1'b1;
            last_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        STREAM: begin
          if (bus.coef_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              idx_q       <= idx_d;
              coef_data_q <= bank_q[idx_d];
              last_q      <= (idx_d == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.addr_err   = addr_err_q;
  assign bus.loaded     = loaded_q;
  assign bus.busy       = busy_q;
  assign bus.coef_valid = valid_q;
  assign bus.coef_data  = coef_data_q;
  assign bus.coef_idx   = idx_q;
  assign bus.coef_last  = last_q;
endmodule

// File: tb/tb_fir_coef_bank.sv
// Randomized self-checking bench for fir_coef_bank against an array-based model of the bank.
module tb_fir_coef_bank;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] model_bank [8];
  logic [7:0] model_loaded;

  fir_coef_bank_if bus ();

  fir_coef_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    for (int k = 0; k < 8; k++) model_bank[k] = 8'h00;
    model_loaded = 8'h00;
  endtask

  // Write through the one-hot port and check the error pulse and loaded flags.
  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    logic exp_err;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ready_idle: got %b want 1", bus.wr_ready);
    end
    bus.wr_en = 1'b1; bus.wr_addr_oh = addr; bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if ($countones(addr) == 1) begin
      for (int k = 0; k < 8; k++) if (addr[k]) model_bank[k] = data;
      model_loaded = model_loaded | addr;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    $display("write addr=%h data=%h addr_err=%b loaded=%h", addr, data, bus.addr_err, bus.loaded);
    checks++;
    if (bus.addr_err !== exp_err) begin
      errors++; $display("FAIL addr_err: got %b want %b (addr %h)", bus.addr_err, exp_err, addr);
    end
    checks++;
    if (bus.loaded !== model_loaded) begin
      errors++; $display("FAIL loaded: got %h want %h", bus.loaded, model_loaded);
    end
    @(negedge clk);
    checks++;
    if (bus.addr_err !== 1'b0) begin
      errors++; $display("FAIL addr_err_pulse: got %b want 0 one cycle later", bus.addr_err);
    end
  endtask

  // Start a stream and check every presented beat against the model bank.
  task automatic run_stream(input int stall_pct, input int hold_idx, input bit intrude,
                            input bit wr0, input logic [7:0] wr0_data);
    int  exp_idx = 0;
    int  holds = 0;
    int  cyc = 0;
    bit  done = 1'b0;
    bit  intruded = 1'b0;
    bit  rdy;
    bus.start = 1'b1;
    bus.coef_ready = 1'b0;
    if (wr0) begin
      bus.wr_en = 1'b1; bus.wr_addr_oh = 8'h01; bus.wr_data = wr0_data;
      model_bank[0] = wr0_data;
      model_loaded[0] = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    while (!done && cyc < 200) begin
      cyc++;
      checks++;
      if (bus.coef_valid !== 1'b1 || bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.addr_err !== 1'b0) begin
        errors++;
        $display("FAIL stream_flags: valid=%b busy=%b wr_ready=%b addr_err=%b want 1 1 0 0",
                 bus.coef_valid, bus.busy, bus.wr_ready, bus.addr_err);
      end
      checks++;
      if (bus.coef_idx !== 3'(exp_idx) || bus.coef_data !== model_bank[exp_idx] ||
          bus.coef_last !== (exp_idx == 7)) begin
        errors++;
        $display("FAIL beat: idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 bus.coef_idx, bus.coef_data, bus.coef_last, exp_idx, model_bank[exp_idx], exp_idx == 7);
      end
      if (exp_idx == hold_idx && holds < 3) begin
        rdy = 1'b0; holds++;
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      bus.coef_ready = rdy;
      if (intrude && exp_idx == 2 && !intruded) begin
        bus.wr_en = 1'b1; bus.wr_addr_oh = 8'h04; bus.wr_data = 8'hFF; bus.start = 1'b1;
        intruded = 1'b1;
      end else begin
        bus.wr_en = 1'b0; bus.start = 1'b0;
      end
      $display("beat idx=%0d data=%h last=%b ready=%b", bus.coef_idx, bus.coef_data, bus.coef_last, rdy);
      @(negedge clk);
      if (rdy) begin
        if (exp_idx == 7) done = 1'b1;
        else exp_idx++;
      end
    end
    bus.coef_ready = 1'b0; bus.wr_en = 1'b0; bus.start = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL stream_timeout: reached idx %0d want 7", exp_idx);
    end
    checks++;
    if (bus.coef_valid !== 1'b0 || bus.busy !== 1'b0 || bus.coef_last !== 1'b0 || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_end: valid=%b busy=%b last=%b wr_ready=%b want 0 0 0 1",
               bus.coef_valid, bus.busy, bus.coef_last, bus.wr_ready);
    end
    checks++;
    if (bus.loaded !== model_loaded) begin
      errors++; $display("FAIL loaded_after_stream: got %h want %h", bus.loaded, model_loaded);
    end
    @(negedge clk);
    checks++;
    if (bus.coef_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL no_restart: valid=%b busy=%b want 0 0", bus.coef_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    $display("reset wr_ready=%b busy=%b valid=%b addr_err=%b loaded=%h",
             bus.wr_ready, bus.busy, bus.coef_valid, bus.addr_err, bus.loaded);
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.coef_valid !== 1'b0 || bus.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: wr_ready=%b busy=%b valid=%b addr_err=%b want 1 0 0 0",
               bus.wr_ready, bus.busy, bus.coef_valid, bus.addr_err);
    end
    checks++;
    if (bus.loaded !== 8'h00 || bus.coef_idx !== 3'd0 || bus.coef_data !== 8'h00 || bus.coef_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: loaded=%h idx=%0d data=%h last=%b want 00 0 00 0",
               bus.loaded, bus.coef_idx, bus.coef_data, bus.coef_last);
    end
  endtask

  task automatic test_load_stream();
    for (int k = 0; k < 8; k++) do_write(8'(1 << k), 8'((k + 1) * 8'h11));
    run_stream(0, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_stall();
    run_stream(0, 3, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_bad_addr();
    do_write(8'h00, 8'hA5);
    do_write(8'h03, 8'h5A);
    run_stream(0, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_busy_ignore();
    run_stream(20, -1, 1'b1, 1'b0, 8'h00);
    run_stream(0, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_write_with_start();
    run_stream(0, -1, 1'b0, 1'b1, 8'($urandom));
  endtask

  task automatic test_random();
    logic [7:0] addr;
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 12; w++) begin
        if ($urandom_range(3) == 0) addr = 8'($urandom_range(255));
        else addr = 8'(1 << $urandom_range(7));
        do_write(addr, 8'($urandom));
      end
      run_stream(40, -1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_reset_midstream();
    int cyc = 0;
    bus.start = 1'b1;
    bus.coef_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.coef_idx !== 3'd5 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (bus.coef_idx !== 3'd5 || bus.coef_valid !== 1'b1) begin
      errors++; $display("FAIL reach_idx5: idx=%0d valid=%b want 5 1", bus.coef_idx, bus.coef_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.coef_ready = 1'b0;
    model_clear();
    $display("midstream reset valid=%b busy=%b loaded=%h", bus.coef_valid, bus.busy, bus.loaded);
    checks++;
    if (bus.coef_valid !== 1'b0 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b1 || bus.loaded !== 8'h00 ||
        bus.coef_idx !== 3'd0 || bus.coef_data !== 8'h00 || bus.coef_last !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: valid=%b busy=%b wr_ready=%b loaded=%h idx=%0d data=%h last=%b want 0 0 1 00 0 00 0",
               bus.coef_valid, bus.busy, bus.wr_ready, bus.loaded, bus.coef_idx, bus.coef_data, bus.coef_last);
    end
    run_stream(0, -1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr_oh = 8'h00;
    bus.wr_data = 8'h00;
    bus.start = 1'b0;
    bus.coef_ready = 1'b0;
    model_clear();
    test_reset();
    test_load_stream();
    test_stall();
    test_bad_addr();
    test_busy_ignore();
    test_write_with_start();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_coef_bank.md
Name: fir_coef_bank

Overview:
- Downstream consumer of the one-hot 8-bit tap address produced by the tap-address encoder in the 2D FIR datapath.
- Holds the 8 filter coefficients in a register bank. Each coefficient is written through the one-hot address.
- On request, streams all 8 coefficients in index order to the MAC stage over a valid/ready handshake.

Parameters:
- COEF_W, 8, coefficient width in bits (signed two's complement, passed through unchanged).
- NTAPS, 8, number of entries. Fixed to the one-hot address width; not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- wr_en  input  1  write request.
- wr_addr_oh  input  8  one-hot entry select from the tap-address encoder.
- wr_data  input  COEF_W  coefficient to write.
- wr_ready  output  1  bank accepts writes (high only in IDLE).
- addr_err  output  1  one-cycle pulse: rejected write with non-one-hot address.
- loaded  output  8  per-entry written flags.
- start  input  1  request a coefficient stream.
- busy  output  1  stream in progress.
- coef_valid  output  1  coef_data/coef_idx valid.
- coef_ready  input  1  MAC stage accepts the current coefficient.
- coef_data  output  COEF_W  coefficient value.
- coef_idx  output  3  entry index of coef_data.
- coef_last  output  1  marks entry 7.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low; it is sampled on clk rising edges only.
- Reset (rst_n=0 at an edge):
  - All bank entries are cleared to 0 and loaded is set to 0.
  - The state machine goes to IDLE.
  - coef_valid, coef_last, busy and addr_err are 0; coef_data and coef_idx are 0; wr_ready is 1.
  - Reset overrides every other input, including mid-stream.
- State machine: IDLE and STREAM.
- Write path (IDLE only):
  - A write is taken when wr_en and wr_ready are both 1.
  - If wr_addr_oh has exactly one bit k set: entry k receives wr_data and loaded[k] is set at that edge.
  - If wr_addr_oh is 0 or has more than one bit set: nothing is written, loaded is unchanged, and addr_err is 1 for the following cycle only.
  - Writing the same entry again overwrites it; loaded[k] stays 1.
  - In STREAM, wr_ready is 0 and wr_en is ignored. No write happens and addr_err is not raised.
- Stream start:
  - In IDLE, start=1 at edge N moves the block to STREAM.
  - After edge N: busy=1, coef_valid=1, coef_idx=0, coef_data=entry0. This is one-cycle latency from start.
  - If wr_en and start are both 1 in the same IDLE cycle, the write completes at that edge and the stream starts. The stream sees the new value.
  - start while in STREAM is ignored (not queued).
- Handshake:
  - A transfer happens at an edge where coef_valid and coef_ready are both 1.
  - While coef_ready=0, coef_data, coef_idx and coef_last hold stable and coef_valid stays 1.
  - After a transfer of index i<7, the outputs present index i+1 at the next edge. With coef_ready held at 1 this gives zero bubbles: 8 consecutive cycles.
- End of stream:
  - coef_last=1 exactly when coef_idx=7.
  - On the transfer of index 7: the block returns to IDLE, and coef_valid, coef_last and busy go to 0 at that edge. wr_ready returns to 1 in the same cycle.
- Unloaded entries stream as 0. Streaming is permitted with an incomplete bank; loaded reports which entries are real.
- All outputs are registered except wr_ready, which is decoded from the state register.

Decomposition:
- Package fir_coef_pkg holds:
  - NTAPS = 8 and IDX_W = 3.
  - The state enum {IDLE, STREAM}.
  - The default coefficient width constant.
- Sub-module oh_to_idx (combinational): 8-bit one-hot in; 3-bit index and an is_onehot flag out.
  - This is the inverse of the upstream encoder's mapping, so it is shared for reuse by other stages.

Test Plan:
- Reset release -> wr_ready=1; busy, coef_valid and addr_err = 0; loaded=0x00.
- Write addresses 0x01, 0x02, 0x04 ... 0x80 with data 0x11..0x88, then pulse start with coef_ready=1 -> loaded=0xFF; 8 consecutive beats of 0x11..0x88 with idx 0..7; coef_last only on 0x88; busy low the cycle after.
- Stream with coef_ready=0 for 3 cycles while idx=3 -> 0x44 and idx 3 held stable with valid=1; stream resumes with 0x55 after ready returns.
- Write with wr_addr_oh=0x00, then 0x03 -> two single-cycle addr_err pulses; loaded and contents unchanged on re-stream.
- During a stream: wr_en=1 to 0x04 with data 0xFF, and a second start -> wr_ready=0, entry 2 unchanged, stream runs once only.
- rst_n=0 for one cycle at idx 5 -> next edge: coef_valid=0, IDLE, loaded=0x00; a new stream outputs all zeros.
